auth_blk_multi: RTL and testbench

- Second-generation rider authentication controller for the segway power path.
- Receives bytes over UART through the existing UART_rx. Asserts pwr_up only after a parametrised multi-byte unlock code arrives.
- Drops to the shutdown-pending state on an explicit stop byte or on loss of the app heartbeat.
- Adds lockout after repeated bad codes. Sits between the BLE UART pin and the power/balance control enable.

---
 rtl/auth_pkg.sv | 29 ++
 rtl/UART_rx.sv | 64 ++++++
 rtl/auth_code_matcher.sv | 67 ++++++
 rtl/auth_blk_multi.sv | 165 ++++++++++++++++
 tb/tb_auth_blk_multi.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/auth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : auth_pkg
// Brief    : Shared types, command bytes and unlock-code helper for auth_blk_multi
// Revision : 2.0 - multi-byte unlock code, lockout and heartbeat
// ============================================================================
package auth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCKOUT  = 2'd1,
        ST_ON       = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_STOP = 8'h53;

    // Byte i of a code of len bytes; byte 0 is the most significant, sent first.
    function automatic logic [7:0] code_byte(input logic [31:0] code,
                                             input int len,
                                             input int i);
        logic [31:0] sh;
        sh = code >> (8 * (len - 1 - i));
        return sh[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/UART_rx.sv
`default_nettype none
// ============================================================================
// Module   : UART_rx
// Brief    : 8N1 UART receiver; rdy holds until clr_rdy or the next start bit
// Revision : 1.0 - existing receiver
// ============================================================================
module UART_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int CW = $clog2(BAUD_DIV * 2);

    logic          r_rx_ff1;
    logic          r_rx_ff2;
    logic          r_busy;
    logic [3:0]    r_bit_cnt;
    logic [CW-1:0] r_baud_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_ff2   <= 1'b1;
            r_busy     <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= '0;
            rx_data    <= 8'h00;
            rdy        <= 1'b0;
        end else begin
            r_rx_ff1 <= RX;
            r_rx_ff2 <= r_rx_ff1;
            if (clr_rdy)
                rdy <= 1'b0;
            if (!r_busy) begin
                // First sample lands mid-way through data bit 0.
                if (!r_rx_ff2) begin
                    r_busy     <= 1'b1;
                    r_bit_cnt  <= 4'd0;
                    r_baud_cnt <= CW'(BAUD_DIV + BAUD_DIV / 2 - 1);
                    rdy        <= 1'b0;
                end
            end else if (r_baud_cnt != '0) begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end else begin
                r_baud_cnt <= CW'(BAUD_DIV - 1);
                if (r_bit_cnt == 4'd8) begin
                    r_busy <= 1'b0;
                    rdy    <= 1'b1;
                end else begin
                    rx_data   <= {r_rx_ff2, rx_data[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/auth_code_matcher.sv
`default_nettype none
// ============================================================================
// Module   : auth_code_matcher
// Brief    : Tracks progress through the unlock code with an inter-byte timeout
// Revision : 2.0 - initial multi-byte matcher
// ============================================================================
module auth_code_matcher
    import auth_pkg::*;
#(
    parameter int                      CODE_LEN    = 2,
    parameter logic [8*CODE_LEN-1:0]   UNLOCK_CODE = 16'h4731,
    parameter int                      HB_TIMEOUT  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       byte_vld,
    input  logic [7:0] byte_data,
    output logic       code_ok,
    output logic       code_bad
);

    localparam int TW = $clog2(HB_TIMEOUT + 1);

    logic [1:0]    r_idx;
    logic [TW-1:0] r_tmr;
    logic [7:0]    w_exp;
    logic          w_active;
    logic          w_match;
    logic          w_last;

    assign w_exp    = code_byte(32'(UNLOCK_CODE), CODE_LEN, int'(r_idx));
    assign w_active = enable && !clear;
    assign w_match  = (byte_data == w_exp);
    assign w_last   = (r_idx == 2'(CODE_LEN - 1));
    assign code_ok  = w_active && byte_vld && w_match && w_last;
    assign code_bad = w_active && byte_vld && !w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            r_tmr <= '0;
        end else if (!w_active) begin
            r_idx <= 2'd0;
            r_tmr <= '0;
        end else if (byte_vld) begin
            // A wrong byte restarts the code; it is never taken as a new first byte.
            if (w_match && !w_last) begin
                r_idx <= r_idx + 2'd1;
                r_tmr <= TW'(HB_TIMEOUT);
            end else begin
                r_idx <= 2'd0;
                r_tmr <= '0;
            end
        end else if (r_idx != 2'd0) begin
            if (r_tmr <= TW'(1)) begin
                r_idx <= 2'd0;
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/auth_blk_multi.sv
`default_nettype none
// ============================================================================
// Module   : auth_blk_multi
// Brief    : Rider authentication: multi-byte unlock, heartbeat, bad-code lockout
// Revision : 2.0 - second-generation controller
// ============================================================================
module auth_blk_multi
    import auth_pkg::*;
#(
    parameter int                      CODE_LEN    = 2,
    parameter logic [8*CODE_LEN-1:0]   UNLOCK_CODE = 16'h4731,
    parameter logic [7:0]              STOP_CMD    = CMD_STOP,
    parameter int                      HB_TIMEOUT  = 50_000_000,
    parameter int                      MAX_FAILS   = 3,
    parameter int                      LOCKOUT_CYC = 250_000_000,
    parameter int                      BAUD_DIV    = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       locked,
    output logic       link_lost,
    output logic [2:0] fail_cnt
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_LOCKOUT  = ST_LOCKOUT;
    localparam logic [1:0] S_ON       = ST_ON;
    localparam logic [1:0] S_STOPPING = ST_STOPPING;

    localparam int TMR_MAX = (HB_TIMEOUT > LOCKOUT_CYC) ? HB_TIMEOUT : LOCKOUT_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    logic [7:0]    rx_data;
    logic          rdy;
    logic          clr_rdy;
    logic          code_ok;
    logic          code_bad;
    logic          w_match_en;
    logic          w_match_clr;

    logic [1:0]    r_state, w_nxt_state;
    logic [2:0]    r_fail,  w_nxt_fail;
    logic          r_ll,    w_nxt_ll;
    logic [TW-1:0] r_tmr,   w_nxt_tmr;

    assign clr_rdy = rdy;

    UART_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
    );

    assign w_match_en  = (r_state == S_IDLE) || (r_state == S_STOPPING);
    assign w_match_clr = (r_state == S_STOPPING) && rider_off;

    auth_code_matcher #(
        .CODE_LEN    (CODE_LEN),
        .UNLOCK_CODE (UNLOCK_CODE),
        .HB_TIMEOUT  (HB_TIMEOUT)
    ) u_matcher (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (w_match_en),
        .clear     (w_match_clr),
        .byte_vld  (rdy),
        .byte_data (rx_data),
        .code_ok   (code_ok),
        .code_bad  (code_bad)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_fail  = r_fail;
        w_nxt_ll    = r_ll;
        w_nxt_tmr   = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (code_ok) begin
                    w_nxt_state = S_ON;
                    w_nxt_fail  = 3'd0;
                    w_nxt_ll    = 1'b0;
                    w_nxt_tmr   = TW'(HB_TIMEOUT);
                end else if (code_bad) begin
                    if (r_fail >= 3'(MAX_FAILS - 1)) begin
                        w_nxt_state = S_LOCKOUT;
                        w_nxt_fail  = 3'd0;
                        w_nxt_tmr   = TW'(LOCKOUT_CYC);
                    end else begin
                        w_nxt_fail  = r_fail + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_tmr <= TW'(1)) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_tmr   = '0;
                end else begin
                    w_nxt_tmr   = r_tmr - 1'b1;
                end
            end
            S_ON: begin
                if (rdy) begin
                    w_nxt_tmr = TW'(HB_TIMEOUT);
                    if (rx_data == STOP_CMD)
                        w_nxt_state = S_STOPPING;
                end else if (r_tmr <= TW'(1)) begin
                    w_nxt_state = S_STOPPING;
                    w_nxt_ll    = 1'b1;
                    w_nxt_tmr   = '0;
                end else begin
                    w_nxt_tmr   = r_tmr - 1'b1;
                end
            end
            S_STOPPING: begin
                // rider_off outranks a simultaneous byte, which is dropped.
                if (rider_off) begin
                    w_nxt_state = S_IDLE;
                end else if (code_ok) begin
                    w_nxt_state = S_ON;
                    w_nxt_fail  = 3'd0;
                    w_nxt_ll    = 1'b0;
                    w_nxt_tmr   = TW'(HB_TIMEOUT);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_fail  = 3'd0;
                w_nxt_ll    = 1'b0;
                w_nxt_tmr   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_fail    <= 3'd0;
            r_ll      <= 1'b0;
            r_tmr     <= '0;
            pwr_up    <= 1'b0;
            locked    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_fail    <= w_nxt_fail;
            r_ll      <= w_nxt_ll;
            r_tmr     <= w_nxt_tmr;
            pwr_up    <= (w_nxt_state == S_ON) || (w_nxt_state == S_STOPPING);
            locked    <= (w_nxt_state == S_LOCKOUT);
        end
    end

    assign link_lost = r_ll;
    assign fail_cnt  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_auth_blk_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_auth_blk_multi
// Brief    : Directed and randomized bench for auth_blk_multi with a cycle-stamp model
// Revision : 2.0 - initial bench
// ============================================================================
module tb_auth_blk_multi;

    localparam int BAUD = 16;
    localparam int HB   = 2000;
    localparam int LCK  = 5000;
    localparam int MAXF = 3;

    localparam int M_IDLE = 0;
    localparam int M_LOCK = 1;
    localparam int M_ON   = 2;
    localparam int M_STOP = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       RX        = 1'b1;
    logic       rider_off = 1'b0;
    wire        pwr_up;
    wire        locked;
    wire        link_lost;
    wire  [2:0] fail_cnt;

    always #5 clk = ~clk;

    auth_blk_multi #(
        .CODE_LEN    (2),
        .UNLOCK_CODE (16'h4731),
        .STOP_CMD    (8'h53),
        .HB_TIMEOUT  (HB),
        .MAX_FAILS   (MAXF),
        .LOCKOUT_CYC (LCK),
        .BAUD_DIV    (BAUD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .locked    (locked),
        .link_lost (link_lost),
        .fail_cnt  (fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte events are timestamped; timeouts are cycle differences.
    logic [7:0] sent_q[$];
    logic [7:0] code_tbl [2] = '{8'h47, 8'h31};
    int         m_state = M_IDLE;
    int         m_idx   = 0;
    int         m_fail  = 0;
    bit         m_ll    = 1'b0;
    longint     cyc      = 0;
    longint     last_evt = 0;
    longint     lock_end = 0;
    bit         m_ev;
    logic [7:0] m_b;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = M_IDLE;
                m_idx   = 0;
                m_fail  = 0;
                m_ll    = 1'b0;
            end else begin
                cyc++;
                m_ev = (u_dut.rdy === 1'b1);
                m_b  = 8'h00;
                if (m_ev) begin
                    if (sent_q.size() == 0) begin
                        check("rx_unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        m_b = sent_q.pop_front();
                        check("rx_data", 32'(u_dut.rx_data), 32'(m_b));
                    end
                end
                case (m_state)
                    M_IDLE, M_STOP: begin
                        if (m_state == M_STOP && rider_off) begin
                            m_state = M_IDLE;
                            m_idx   = 0;
                        end else if (m_ev) begin
                            if (m_b == code_tbl[m_idx]) begin
                                if (m_idx == 1) begin
                                    m_state = M_ON;
                                    m_idx   = 0;
                                    m_fail  = 0;
                                    m_ll    = 1'b0;
                                end else begin
                                    m_idx++;
                                end
                            end else begin
                                m_idx = 0;
                                if (m_state == M_IDLE) begin
                                    m_fail++;
                                    if (m_fail == MAXF) begin
                                        m_state  = M_LOCK;
                                        lock_end = cyc + LCK;
                                        m_fail   = 0;
                                    end
                                end
                            end
                        end else if (m_idx != 0 && cyc - last_evt >= HB) begin
                            m_idx = 0;
                        end
                    end
                    M_LOCK: begin
                        if (cyc >= lock_end) begin
                            m_state = M_IDLE;
                            m_idx   = 0;
                        end
                    end
                    default: begin
                        if (m_ev) begin
                            if (m_b == 8'h53)
                                m_state = M_STOP;
                        end else if (cyc - last_evt >= HB) begin
                            m_state = M_STOP;
                            m_ll    = 1'b1;
                        end
                    end
                endcase
                if (m_ev)
                    last_evt = cyc;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("pwr_up",    32'(pwr_up),    32'(m_state == M_ON || m_state == M_STOP));
            check("locked",    32'(locked),    32'(m_state == M_LOCK));
            check("link_lost", 32'(link_lost), 32'(m_ll));
            check("fail_cnt",  32'(fail_cnt),  32'(m_fail));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        sent_q.push_back(b);
        RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cyc(BAUD);
        end
        RX = 1'b1;
        wait_cyc(BAUD);
    endtask

    // Raises rider_off in exactly the cycle the byte's rdy is high.
    task automatic send_byte_ro(input logic [7:0] b);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        fork
            send_byte(b);
            begin
                while (!seen && n < BAUD * 10) begin
                    @(negedge clk);
                    n++;
                    if (u_dut.rdy === 1'b1) begin
                        rider_off = 1'b1;
                        seen      = 1'b1;
                    end
                end
            end
        join
        check("ro_with_rdy_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        check("rst_pwr_up",    32'(pwr_up),    32'd0);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_link_lost", 32'(link_lost), 32'd0);
        check("rst_fail_cnt",  32'(fail_cnt),  32'd0);

        send_byte(8'h47);
        send_byte(8'h31);
        check("unlock_pwr_up",   32'(pwr_up),   32'd1);
        check("unlock_fail_cnt", 32'(fail_cnt), 32'd0);
        send_byte(8'h41);
        check("stray_pwr_up", 32'(pwr_up), 32'd1);

        send_byte(8'h53);
        wait_cyc(5);
        check("stop_pwr_up", 32'(pwr_up), 32'd1);
        rider_off = 1'b1;
        wait_cyc(2);
        check("rider_off_pwr_up", 32'(pwr_up), 32'd0);
        rider_off = 1'b0;

        send_byte(8'h47); send_byte(8'h00);
        check("bad1_fail_cnt", 32'(fail_cnt), 32'd1);
        send_byte(8'h47); send_byte(8'h00);
        check("bad2_fail_cnt", 32'(fail_cnt), 32'd2);
        send_byte(8'h47); send_byte(8'h00);
        check("bad3_locked",   32'(locked),   32'd1);
        check("bad3_fail_cnt", 32'(fail_cnt), 32'd0);
        send_byte(8'h47); send_byte(8'h31);
        check("lock_code_pwr_up", 32'(pwr_up), 32'd0);
        check("lock_code_locked", 32'(locked), 32'd1);
        wait_cyc(LCK);
        check("lock_done_locked", 32'(locked), 32'd0);
        send_byte(8'h47); send_byte(8'h31);
        check("post_lock_pwr_up", 32'(pwr_up), 32'd1);

        wait_cyc(HB + 100);
        check("hb_link_lost", 32'(link_lost), 32'd1);
        check("hb_pwr_up",    32'(pwr_up),    32'd1);
        send_byte(8'h47); send_byte(8'h31);
        check("relock_link_lost", 32'(link_lost), 32'd0);
        check("relock_pwr_up",    32'(pwr_up),    32'd1);
        wait_cyc(HB + 100);
        rider_off = 1'b1;
        wait_cyc(2);
        check("hb_off_pwr_up",    32'(pwr_up),    32'd0);
        check("hb_off_link_lost", 32'(link_lost), 32'd1);
        rider_off = 1'b0;

        send_byte(8'h47);
        wait_cyc(HB + 100);
        send_byte(8'h31);
        check("ibt_pwr_up",   32'(pwr_up),   32'd0);
        check("ibt_fail_cnt", 32'(fail_cnt), 32'd1);

        send_byte(8'h47); send_byte(8'h31);
        send_byte(8'h53);
        check("stopping_pwr_up", 32'(pwr_up), 32'd1);
        send_byte_ro(8'h47);
        check("ro_rdy_pwr_up", 32'(pwr_up), 32'd0);
        rider_off = 1'b0;
        send_byte(8'h31);
        check("ro_rdy_fail_cnt", 32'(fail_cnt), 32'd1);
        check("ro_rdy_pwr_off",  32'(pwr_up),   32'd0);

        send_byte(8'h47); send_byte(8'h31);
        check("pre_rst_pwr_up", 32'(pwr_up), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwr_up", 32'(pwr_up), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);

        for (int k = 0; k < 70; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: send_byte(8'h47);
                3, 4, 5: send_byte(8'h31);
                6:       send_byte(8'h53);
                7:       send_byte(8'($urandom_range(0, 255)));
                8:       rider_off = ~rider_off;
                default: wait_cyc(1820 + $urandom_range(0, 190));
            endcase
            wait_cyc($urandom_range(0, 30));
        end
        rider_off = 1'b0;
        wait_cyc(300);
        check("rx_queue_drained", 32'(sent_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
